// File: rtl/rv_pkg.sv
// Shared decode-stage definitions.
// Holds the register-file geometry defaults, the latency-field width helper,
// and the latency codes that decode places on rd_lat_id.
package rv_pkg;

  localparam int AW_DEFAULT   = 5;
  localparam int NREG_DEFAULT = 32;

  // Latency codes: 0 means plain ALU forwarding covers the result.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  // Width needed to hold a countdown value in 0..max_lat.
  function automatic int lat_width(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/load_scoreboard_sb_counter.sv
// Per-register pending-latency countdown.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   arm        : load arm_val this edge (takes priority over decrement)
//   arm_val    : latency to load
//   cnt        : current countdown, saturates at 0
module sb_counter #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic [LW-1:0] arm_val,
  output logic [LW-1:0] cnt
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arm) begin
      cnt_d = arm_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/load_scoreboard.sv
// Decode-stage hazard scoreboard.
// Tracks, per architectural register, how many cycles remain until its
// pending result becomes forwardable, and stalls ID on RAW hazards against
// used sources and on WAW hazards against an older, longer-latency write.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid, flush            : ID occupancy and kill
//   rs1/rs2_addr_id, *_used    : source operands
//   rd_addr_id, rd_write_id    : destination
//   rd_lat_id                  : result latency (clamped to MAX_LAT)
//   stall, if_write, issue     : combinational pipeline control
//   busy_vec                   : per-register pending flags
//   stall_cycles               : saturating stalled-cycle counter
module load_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG    = NREG_DEFAULT,
  parameter int AW      = AW_DEFAULT,
  parameter int MAX_LAT = 7,
  parameter int LW      = lat_width(MAX_LAT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            flush,
  input  logic [AW-1:0]   rs1_addr_id,
  input  logic [AW-1:0]   rs2_addr_id,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [AW-1:0]   rd_addr_id,
  input  logic            rd_write_id,
  input  logic [LW-1:0]   rd_lat_id,
  output logic            stall,
  output logic            if_write,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic [31:0]     stall_cycles
);

  localparam logic [LW-1:0] MAX_LAT_V = LW'(MAX_LAT);

  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] eff_lat;
  logic [LW-1:0] cnt_rs1;
  logic [LW-1:0] cnt_rs2;
  logic [LW-1:0] cnt_rd;
  logic          haz_rs1;
  logic          haz_rs2;
  logic          haz_waw;
  logic [31:0]   stall_cycles_q;
  logic [31:0]   stall_cycles_d;

  assign cnt[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      sb_counter #(.LW(LW)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (issue && rd_write_id && (rd_addr_id == AW'(g))),
        .arm_val (eff_lat),
        .cnt     (cnt[g])
      );
    end
  endgenerate

  // Addresses beyond NREG-1 (possible when 2^AW > NREG) read as idle.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rd  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rs1_addr_id == AW'(r)) cnt_rs1 = cnt[r];
      if (rs2_addr_id == AW'(r)) cnt_rs2 = cnt[r];
      if (rd_addr_id  == AW'(r)) cnt_rd  = cnt[r];
    end
  end

  always_comb begin
    eff_lat  = (rd_lat_id > MAX_LAT_V) ? MAX_LAT_V : rd_lat_id;
    haz_rs1  = rs1_used && (cnt_rs1 != '0);
    haz_rs2  = rs2_used && (cnt_rs2 != '0);
    haz_waw  = rd_write_id && (rd_addr_id != '0) && (cnt_rd > eff_lat);
    stall    = id_valid && !flush && (haz_rs1 || haz_rs2 || haz_waw);
    issue    = id_valid && !flush && !stall;
    if_write = !stall;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, flush = 1'b0;
  logic [4:0]  rs1_addr_id = '0, rs2_addr_id = '0, rd_addr_id = '0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0, rd_write_id = 1'b0;
  logic [2:0]  rd_lat_id = '0;
  logic        stall, if_write, issue;
  logic [31:0] busy_vec;
  logic [31:0] stall_cycles;

  // Second instance with a smaller MAX_LAT to exercise latency clamping.
  logic        c_valid = 1'b0, c_write = 1'b0;
  logic [4:0]  c_rd = '0;
  logic [2:0]  c_lat = '0;
  logic        c_stall, c_if_write, c_issue;
  logic [31:0] c_busy;
  logic [31:0] c_sc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(7)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .flush(flush),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_addr_id(rd_addr_id), .rd_write_id(rd_write_id), .rd_lat_id(rd_lat_id),
    .stall(stall), .if_write(if_write), .issue(issue),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  load_scoreboard #(.NREG(32), .AW(5), .MAX_LAT(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(c_valid), .flush(1'b0),
    .rs1_addr_id(5'd0), .rs2_addr_id(5'd0),
    .rs1_used(1'b0), .rs2_used(1'b0),
    .rd_addr_id(c_rd), .rd_write_id(c_write), .rd_lat_id(c_lat),
    .stall(c_stall), .if_write(c_if_write), .issue(c_issue),
    .busy_vec(c_busy), .stall_cycles(c_sc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic fl,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic [2:0] lat);
    id_valid = v; flush = fl;
    rs1_addr_id = r1; rs1_used = u1;
    rs2_addr_id = r2; rs2_used = u2;
    rd_addr_id = rd; rd_write_id = wr; rd_lat_id = lat;
  endtask

  typedef struct {
    logic v, fl;
    logic [4:0] r1; logic u1;
    logic [4:0] r2; logic u2;
    logic [4:0] rd; logic wr; logic [2:0] lat;
    logic e_stall, e_issue;
    logic [31:0] e_busy;
    logic [31:0] e_sc;
  } vec_t;

  vec_t tbl[24];

  // Reference model state
  int      mcnt[32];
  longint  msc;

  initial begin
    logic [31:0] b5, b7, b9, b10, b11;
    b5 = 32'd1 << 5; b7 = 32'd1 << 7; b9 = 32'd1 << 9;
    b10 = 32'd1 << 10; b11 = 32'd1 << 11;

    //           v  fl r1 u1 r2 u2 rd wr lat         st is busy sc
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 5, 1, 3'(LAT_LOAD), 0, 1, 0,   0}; // lw x5
    tbl[1]  = '{1, 0, 5, 1, 1, 1, 6, 1, 3'(LAT_ALU),  1, 0, b5,  0}; // add x6,x5,x1
    tbl[2]  = '{1, 0, 5, 1, 1, 1, 6, 1, 3'(LAT_ALU),  0, 1, 0,   1};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 7, 1, 3,            0, 1, 0,   1}; // lat 3 -> x7
    tbl[4]  = '{1, 0, 0, 0, 7, 1, 8, 1, 0,            1, 0, b7,  1};
    tbl[5]  = '{1, 0, 0, 0, 7, 1, 8, 1, 0,            1, 0, b7,  2};
    tbl[6]  = '{1, 0, 0, 0, 7, 1, 8, 1, 0,            1, 0, b7,  3};
    tbl[7]  = '{1, 0, 0, 0, 7, 1, 8, 1, 0,            0, 1, 0,   4};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 3,            0, 1, 0,   4}; // rd = x0
    tbl[9]  = '{1, 0, 0, 1, 0, 1, 0, 0, 0,            0, 1, 0,   4};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 9, 1, 5,            0, 1, 0,   4}; // WAW x9
    tbl[11] = '{1, 0, 0, 0, 0, 0, 9, 1, 1,            1, 0, b9,  4}; // cnt 5
    tbl[12] = '{1, 0, 0, 0, 0, 0, 9, 1, 1,            1, 0, b9,  5}; // cnt 4
    tbl[13] = '{1, 0, 0, 0, 0, 0, 9, 1, 1,            1, 0, b9,  6}; // cnt 3
    tbl[14] = '{1, 0, 0, 0, 0, 0, 9, 1, 1,            1, 0, b9,  7}; // cnt 2
    tbl[15] = '{1, 0, 0, 0, 0, 0, 9, 1, 1,            0, 1, b9,  8}; // cnt 1
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, b9,  8}; // rearmed to 1
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,   8};
    tbl[18] = '{1, 0, 0, 0, 0, 0,10, 1, 2,            0, 1, 0,   8}; // x10 lat 2
    tbl[19] = '{1, 1,10, 1, 0, 0, 0, 0, 0,            0, 0, b10, 8}; // flushed
    tbl[20] = '{1, 1,10, 1, 0, 0, 0, 0, 0,            0, 0, b10, 8};
    tbl[21] = '{1, 1,10, 1, 0, 0, 0, 0, 0,            0, 0, 0,   8};
    tbl[22] = '{1, 0,11, 1, 0, 0,11, 1, 4,            0, 1, 0,   8}; // self-dep
    tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, b11, 8};

    // Reset state
    #12;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_if_write", {31'd0, if_write}, 32'd1);
    check("rst_issue", {31'd0, issue}, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    check("rst_sc", stall_cycles, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].fl, tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2,
            tbl[i].rd, tbl[i].wr, tbl[i].lat);
      #1;
      check($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      check($sformatf("tbl%0d_if_write", i), {31'd0, if_write}, {31'd0, ~tbl[i].e_stall});
      check($sformatf("tbl%0d_issue", i), {31'd0, issue}, {31'd0, tbl[i].e_issue});
      check($sformatf("tbl%0d_busy", i), busy_vec, tbl[i].e_busy);
      check($sformatf("tbl%0d_sc", i), stall_cycles, tbl[i].e_sc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Clamp: top latency code on MAX_LAT=7 loads 7; 7 on MAX_LAT=5 loads 5.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 12, 1, 3'd7);
    c_valid = 1'b1; c_write = 1'b1; c_rd = 5'd3; c_lat = 3'd7;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    c_valid = 1'b0; c_write = 1'b0;
    check("clamp_max7", 32'(dut.cnt[12]), 32'd7);
    check("clamp_max5", 32'(dut_c.cnt[3]), 32'd5);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("clamp_drained", busy_vec, 32'd0);

    // Saturation: preload near the top, then keep stalling.
    drive(1, 0, 0, 0, 0, 0, 13, 1, 4);
    force dut.stall_cycles_d = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stall_cycles_d;
    drive(1, 0, 13, 1, 0, 0, 14, 1, 0);
    #1;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    check("sat_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    check("sat_top", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) @(negedge clk);

    // Asynchronous reset mid-countdown
    drive(1, 0, 0, 0, 0, 0, 3, 1, 4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("arst_pre_busy", busy_vec, 32'd1 << 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_vec, 32'd0);
    check("arst_sc", stall_cycles, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized run against the reference model
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    msc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, fl, u1, u2, wr;
      logic [4:0] r1, r2, rd;
      logic [2:0] lat;
      int eff;
      bit hz, mstall, missue;
      logic [31:0] mbusy;
      @(negedge clk);
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 9) == 0);
      r1 = 5'($urandom_range(0, 7)); u1 = 1'($urandom);
      r2 = 5'($urandom_range(0, 7)); u2 = 1'($urandom);
      rd = 5'($urandom_range(0, 7)); wr = 1'($urandom);
      lat = 3'($urandom_range(0, 7));
      drive(v, fl, r1, u1, r2, u2, rd, wr, lat);
      eff = (int'(lat) > 7) ? 7 : int'(lat);
      hz = (u1 && mcnt[r1] > 0) || (u2 && mcnt[r2] > 0) ||
           (wr && rd != 0 && mcnt[rd] > eff);
      mstall = v && !fl && hz;
      missue = v && !fl && !mstall;
      mbusy = '0;
      for (int r = 0; r < 32; r++) if (mcnt[r] > 0) mbusy[r] = 1'b1;
      #1;
      check("rnd_stall", {31'd0, stall}, {31'd0, mstall});
      check("rnd_if_write", {31'd0, if_write}, {31'd0, !mstall});
      check("rnd_issue", {31'd0, issue}, {31'd0, missue});
      check("rnd_busy", busy_vec, mbusy);
      check("rnd_sc", stall_cycles, 32'(msc));
      for (int r = 0; r < 32; r++) begin
        if (missue && wr && int'(rd) == r && r != 0) mcnt[r] = eff;
        else if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      end
      if (mstall && msc < 64'hFFFF_FFFF) msc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
